// File: rtl/sccb_init_sequencer.sv
// rtl/sccb_init_sequencer.sv - walks a register table and issues SCCB writes with delays and NACK retry
module sccb_init_sequencer #(
   parameter int         ADDR_W      = 8,
   parameter logic [6:0] DEV_ADDR    = 7'h21,
   parameter int         CLKS_PER_MS = 24000,
   parameter int         MAX_RETRY   = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic [ADDR_W-1:0] ROM_ADDR,
   input  logic [15:0]       ROM_DATA,
   output logic              SCCB_GO,
   output logic [6:0]        SCCB_DEV,
   output logic [7:0]        SCCB_REG,
   output logic [7:0]        SCCB_DATA,
   input  logic              SCCB_BUSY,
   input  logic              SCCB_NACK,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [ADDR_W-1:0] ERR_INDEX
);
   localparam int CNT_W = $clog2(255 * CLKS_PER_MS + 1);
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WAIT_ACCEPT, S_WAIT_XFER,
      S_DELAY, S_NEXT, S_FINISH, S_FAIL
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] delay_cnt;
   logic [RTY_W-1:0] retry;

   assign SCCB_DEV = DEV_ADDR;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         ROM_ADDR  <= '0;
         SCCB_GO   <= 1'b0;
         SCCB_REG  <= 8'h00;
         SCCB_DATA <= 8'h00;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         ERR_INDEX <= '0;
         retry     <= '0;
         delay_cnt <= '0;
      end else begin
         SCCB_GO <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (START) begin
                  ROM_ADDR  <= '0;
                  DONE      <= 1'b0;
                  ERR       <= 1'b0;
                  ERR_INDEX <= '0;
                  retry     <= '0;
                  BUSY      <= 1'b1;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               if (ROM_DATA == 16'hFFFF) begin
                  state <= S_FINISH;
               end else if (ROM_DATA[15:8] == 8'hFF) begin
                  // Zero-length delay skips the DELAY state entirely.
                  if (ROM_DATA[7:0] == 8'h00) begin
                     state <= S_NEXT;
                  end else begin
                     delay_cnt <= CNT_W'(ROM_DATA[7:0]) * CNT_W'(CLKS_PER_MS);
                     state     <= S_DELAY;
                  end
               end else begin
                  SCCB_REG  <= ROM_DATA[15:8];
                  SCCB_DATA <= ROM_DATA[7:0];
                  SCCB_GO   <= 1'b1;
                  state     <= S_WAIT_ACCEPT;
               end
            end
            S_WAIT_ACCEPT: begin
               if (SCCB_BUSY) state <= S_WAIT_XFER;
            end
            S_WAIT_XFER: begin
               if (!SCCB_BUSY) begin
                  if (!SCCB_NACK) begin
                     retry <= '0;
                     state <= S_NEXT;
                  end else if (retry < RTY_W'(MAX_RETRY)) begin
                     retry   <= retry + RTY_W'(1);
                     SCCB_GO <= 1'b1;
                     state   <= S_WAIT_ACCEPT;
                  end else begin
                     ERR_INDEX <= ROM_ADDR;
                     state     <= S_FAIL;
                  end
               end
            end
            S_DELAY: begin
               if (delay_cnt == CNT_W'(1)) begin
                  delay_cnt <= '0;
                  state     <= S_NEXT;
               end else begin
                  delay_cnt <= delay_cnt - CNT_W'(1);
               end
            end
            S_NEXT: begin
               // The last table slot ends the run rather than wrapping to 0.
               if (ROM_ADDR == '1) begin
                  state <= S_FINISH;
               end else begin
                  ROM_ADDR <= ROM_ADDR + ADDR_W'(1);
                  state    <= S_FETCH;
               end
            end
            S_FINISH: begin
               BUSY  <= 1'b0;
               DONE  <= 1'b1;
               state <= S_IDLE;
            end
            S_FAIL: begin
               BUSY  <= 1'b0;
               ERR   <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// tb/tb_sccb_init_sequencer.sv - table-driven bench with a ROM model and an SCCB slave model
module tb_sccb_init_sequencer;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [2:0]  ROM_ADDR;
   logic [15:0] ROM_DATA = 16'h0000;
   logic        SCCB_GO;
   logic [6:0]  SCCB_DEV;
   logic [7:0]  SCCB_REG;
   logic [7:0]  SCCB_DATA;
   logic        SCCB_BUSY;
   logic        SCCB_NACK = 1'b0;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [2:0]  ERR_INDEX;

   sccb_init_sequencer #(
      .ADDR_W(3), .DEV_ADDR(7'h21), .CLKS_PER_MS(10), .MAX_RETRY(3)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START),
      .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
      .SCCB_GO(SCCB_GO), .SCCB_DEV(SCCB_DEV), .SCCB_REG(SCCB_REG), .SCCB_DATA(SCCB_DATA),
      .SCCB_BUSY(SCCB_BUSY), .SCCB_NACK(SCCB_NACK),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_INDEX(ERR_INDEX)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0][15:0] rom;
      logic [7:0][3:0]  nack;
      logic [7:0]       gos;
      logic             done;
      logic             err;
      logic [2:0]       eidx;
      logic [7:0]       delta;
      logic [15:0]      first;
      logic [15:0]      last;
      logic [2:0]       ci;
      logic [3:0]       cc;
      logic [2:0]       fin;
      logic [2:0]       maxa;
   } vec_t;

   vec_t        vecs[7];
   logic [15:0] rom[8];
   int          nack_plan[8];
   int          idx_base[8];
   int          idx_cnt[8] = '{default: 0};
   int          sl_len = 3;
   int          total = 0;
   int          bad = 0;

   // Slave and ROM model state, written only by the always block below.
   int          cyc = 0;
   int          go_cnt = 0;
   int          unstable = 0;
   int          bad_go = 0;
   int          go_cyc[64];
   logic [15:0] go_word[64];
   logic        sl_busy = 1'b0;
   logic        sl_pend = 1'b0;
   int          sl_cnt = 0;
   int          att;
   logic [7:0]  sl_reg = 8'h00;
   logic [7:0]  sl_data = 8'h00;

   assign SCCB_BUSY = sl_busy;

   always @(posedge CLK) begin
      cyc      <= cyc + 1;
      ROM_DATA <= rom[ROM_ADDR];
      if (sl_busy && (SCCB_REG != sl_reg || SCCB_DATA != sl_data)) unstable <= unstable + 1;
      if (SCCB_GO) begin
         if (sl_busy) bad_go <= bad_go + 1;
         go_word[go_cnt]   <= {SCCB_REG, SCCB_DATA};
         go_cyc[go_cnt]    <= cyc;
         go_cnt            <= go_cnt + 1;
         att                = idx_cnt[ROM_ADDR] - idx_base[ROM_ADDR] + 1;
         sl_pend           <= (att <= nack_plan[ROM_ADDR]);
         idx_cnt[ROM_ADDR] <= idx_cnt[ROM_ADDR] + 1;
         sl_busy           <= 1'b1;
         sl_cnt            <= sl_len;
         SCCB_NACK         <= 1'b0;
         sl_reg            <= SCCB_REG;
         sl_data           <= SCCB_DATA;
      end else if (sl_busy) begin
         if (sl_cnt == 1) begin
            sl_busy   <= 1'b0;
            SCCB_NACK <= sl_pend;
         end else begin
            sl_cnt <= sl_cnt - 1;
         end
      end
   end

   function automatic logic [127:0] tbl(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [31:0] nk(input logic [3:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int v);
      for (int i = 0; i < 8; i++) begin
         rom[i]       = vecs[v].rom[i];
         nack_plan[i] = int'(vecs[v].nack[i]);
         idx_base[i]  = idx_cnt[i];
      end
   endtask

   task automatic run_vec(input int v, input bit poke);
      int g0, u0, b0, c0, n, gos;
      logic [2:0] maxa;
      load(v);
      g0 = go_cnt; u0 = unstable; b0 = bad_go;
      @(negedge CLK); START = 1'b1; c0 = cyc;
      @(negedge CLK); START = 1'b0;
      chk($sformatf("v%0d busy_on", v), 32'(BUSY), 32'd1);
      chk($sformatf("v%0d start_clr", v), 32'({DONE, ERR}), 32'd0);
      maxa = ROM_ADDR;
      n = 0;
      while (!(DONE || ERR) && n < 3000) begin
         @(negedge CLK);
         START = (poke && n == 4);
         if (ROM_ADDR > maxa) maxa = ROM_ADDR;
         n++;
      end
      START = 1'b0;
      chk($sformatf("v%0d timeout", v), 32'(n < 3000), 32'd1);
      repeat (10) @(negedge CLK);
      gos = go_cnt - g0;
      chk($sformatf("v%0d done", v), 32'(DONE), 32'(vecs[v].done));
      chk($sformatf("v%0d err", v), 32'(ERR), 32'(vecs[v].err));
      chk($sformatf("v%0d busy_off", v), 32'(BUSY), 32'd0);
      if (vecs[v].err) chk($sformatf("v%0d err_index", v), 32'(ERR_INDEX), 32'(vecs[v].eidx));
      chk($sformatf("v%0d go_count", v), 32'(gos), 32'(vecs[v].gos));
      if (gos > 0) begin
         chk($sformatf("v%0d first_delta", v), 32'(go_cyc[g0] - c0), 32'(vecs[v].delta));
         chk($sformatf("v%0d first_word", v), 32'(go_word[g0]), 32'(vecs[v].first));
         chk($sformatf("v%0d last_word", v), 32'(go_word[go_cnt-1]), 32'(vecs[v].last));
      end
      chk($sformatf("v%0d entry_gos", v), 32'(idx_cnt[vecs[v].ci] - idx_base[vecs[v].ci]), 32'(vecs[v].cc));
      chk($sformatf("v%0d final_addr", v), 32'(ROM_ADDR), 32'(vecs[v].fin));
      chk($sformatf("v%0d max_addr", v), 32'(maxa), 32'(vecs[v].maxa));
      chk($sformatf("v%0d reg_stable", v), 32'(unstable - u0), 32'd0);
      chk($sformatf("v%0d go_overlap", v), 32'(bad_go - b0), 32'd0);
   endtask

   initial begin
      int g, n;
      for (int i = 0; i < 8; i++) begin
         rom[i] = 16'hFFFF; nack_plan[i] = 0; idx_base[i] = 0;
      end
      //               rom table                                                        nacks                    gos   dn  er  ei  dlt   first     last    ci  cc   fin  max
      vecs[0] = '{tbl(16'h1280,16'h1100,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), nk(0,0,0,0,0,0,0,0), 8'd2, 1'b1, 1'b0, 3'd0, 8'd3, 16'h1280, 16'h1100, 3'd0, 4'd1, 3'd2, 3'd2};
      vecs[1] = '{tbl(16'hFF02,16'h3A04,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), nk(0,0,0,0,0,0,0,0), 8'd1, 1'b1, 1'b0, 3'd0, 8'd26, 16'h3A04, 16'h3A04, 3'd1, 4'd1, 3'd2, 3'd2};
      vecs[2] = '{tbl(16'hFF00,16'h3A04,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), nk(0,0,0,0,0,0,0,0), 8'd1, 1'b1, 1'b0, 3'd0, 8'd6, 16'h3A04, 16'h3A04, 3'd1, 4'd1, 3'd2, 3'd2};
      vecs[3] = '{tbl(16'h0101,16'h0202,16'h0303,16'h0404,16'h0505,16'h0606,16'h0707,16'hFFFF), nk(0,0,0,0,0,15,0,0), 8'd9, 1'b0, 1'b1, 3'd5, 8'd3, 16'h0101, 16'h0606, 3'd5, 4'd4, 3'd5, 3'd5};
      vecs[4] = '{tbl(16'h1001,16'h1102,16'h1203,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), nk(0,0,1,0,0,0,0,0), 8'd4, 1'b1, 1'b0, 3'd0, 8'd3, 16'h1001, 16'h1203, 3'd2, 4'd2, 3'd3, 3'd3};
      vecs[5] = '{tbl(16'h2000,16'h2101,16'h2202,16'h2303,16'h2404,16'h2505,16'h2606,16'h2707), nk(0,0,0,0,0,0,0,0), 8'd8, 1'b1, 1'b0, 3'd0, 8'd3, 16'h2000, 16'h2707, 3'd7, 4'd1, 3'd7, 3'd7};
      vecs[6] = '{tbl(16'h5511,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), nk(3,0,0,0,0,0,0,0), 8'd4, 1'b1, 1'b0, 3'd0, 8'd3, 16'h5511, 16'h5511, 3'd0, 4'd4, 3'd1, 3'd1};

      repeat (3) @(negedge CLK);
      chk("reset_flags", 32'({BUSY, DONE, ERR, SCCB_GO}), 32'd0);
      chk("reset_addr", 32'({ROM_ADDR, ERR_INDEX}), 32'd0);
      chk("reset_regdata", 32'({SCCB_REG, SCCB_DATA}), 32'd0);
      chk("dev_addr", 32'(SCCB_DEV), 32'h21);
      RST = 1'b0;
      @(negedge CLK);

      for (int v = 0; v < 7; v++) run_vec(v, 1'b0);

      // START pulsed mid-run must not restart the sequence.
      run_vec(0, 1'b1);

      // Reset while a transfer is in flight.
      load(0);
      sl_len = 8;
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      n = 0;
      while (!SCCB_BUSY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("rst_wait_busy", 32'(n < 50), 32'd1);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_mid_flags", 32'({BUSY, DONE, ERR}), 32'd0);
      chk("rst_mid_addr", 32'(ROM_ADDR), 32'd0);
      RST = 1'b0;
      g = go_cnt;
      repeat (40) @(negedge CLK);
      chk("rst_no_go", 32'(go_cnt - g), 32'd0);
      chk("rst_idle", 32'({BUSY, DONE, ERR}), 32'd0);
      sl_len = 3;
      run_vec(0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Walks a register-initialisation table and drives the SCCB master one write at a time, so the camera sensor is configured after power-up or on demand.
- Sits between the top-level control logic and the SCCB master unit. It owns the master's request, address and data inputs while a sequence runs.
- Supports inline millisecond delays, NACK retry, and error reporting with the index of the failing entry.

Parameters:
- ADDR_W, 8: table address width; up to 2^ADDR_W entries.
- DEV_ADDR, 7'h21: 7-bit SCCB device address driven on SCCB_DEV.
- CLKS_PER_MS, 24000: CLK cycles per millisecond of delay.
- MAX_RETRY, 3: extra attempts after a NACK before the sequence aborts.

Ports:
- CLK, input, 1: system clock; all logic on the rising edge.
- RST, input, 1: reset, synchronous, active-high.
- START, input, 1: single-cycle request to run the table from entry 0.
- ROM_ADDR, output, ADDR_W: table entry index.
- ROM_DATA, input, 16: table word {reg[15:8], value[7:0]}; valid 1 cycle after ROM_ADDR changes.
- SCCB_GO, output, 1: single-cycle write request to the SCCB master.
- SCCB_DEV, output, 7: device address; constant DEV_ADDR.
- SCCB_REG, output, 8: register sub-address.
- SCCB_DATA, output, 8: write value.
- SCCB_BUSY, input, 1: master transfer in progress.
- SCCB_NACK, input, 1: slave did not acknowledge; sampled on the cycle SCCB_BUSY falls.
- BUSY, output, 1: sequence running.
- DONE, output, 1: sequence completed; level signal.
- ERR, output, 1: sequence aborted; level signal.
- ERR_INDEX, output, ADDR_W: entry index that failed.

Behaviour:
- Reset values:
  - state IDLE; ROM_ADDR=0.
  - SCCB_GO=0, SCCB_REG=0, SCCB_DATA=0.
  - BUSY=0, DONE=0, ERR=0, ERR_INDEX=0.
  - retry counter and delay counter both 0.
- RST mid-sequence: returns to IDLE the next edge. No further SCCB_GO is issued; a transfer already in the master is not cancelled.
- IDLE:
  - START=1 → ROM_ADDR=0, DONE=0, ERR=0, retry=0, BUSY=1 → FETCH.
  - START while BUSY=1 is ignored.
- FETCH: one wait cycle for ROM latency → DECODE.
- DECODE, on ROM_DATA:
  - 16'hFFFF: end marker → FINISH.
  - 16'hFFnn, nn≠FF: delay. Load counter with nn*CLKS_PER_MS → DELAY. nn=0 goes directly to NEXT.
  - Anything else: latch SCCB_REG and SCCB_DATA, pulse SCCB_GO for exactly 1 cycle → WAIT_ACCEPT.
- WAIT_ACCEPT: wait for SCCB_BUSY=1 → WAIT_XFER. SCCB_GO is never re-asserted here.
- WAIT_XFER: on the first cycle SCCB_BUSY=0, sample SCCB_NACK.
  - NACK=0: retry=0 → NEXT.
  - NACK=1 and retry<MAX_RETRY: retry+1, re-issue the same entry (SCCB_GO pulse) → WAIT_ACCEPT.
  - NACK=1 and retry=MAX_RETRY: ERR_INDEX=ROM_ADDR → FAIL.
- DELAY: decrement each cycle; at 1 → NEXT. Total stall is exactly nn*CLKS_PER_MS cycles in DELAY.
- NEXT:
  - ROM_ADDR = all-ones: no wrap → FINISH.
  - Otherwise ROM_ADDR+1 → FETCH.
- FINISH: BUSY=0, DONE=1 → IDLE. DONE holds until the next START or RST.
- FAIL: BUSY=0, ERR=1 → IDLE. ERR and ERR_INDEX hold until the next START or RST.
- DONE and ERR are never high simultaneously.
- SCCB_REG and SCCB_DATA hold stable from the SCCB_GO pulse until SCCB_BUSY falls.
- Delay arithmetic: counter width is ceil(log2(255*CLKS_PER_MS+1)); no overflow allowed.

Test Plan:
- Table {1280, 1100, FFFF}, slave always ACKs → two SCCB_GO pulses with REG/DATA 12/80 then 11/00; DONE=1 at the end; ERR=0.
- Table {FF02, 3A04, FFFF}, CLKS_PER_MS=10 → exactly 20 cycles in DELAY; first SCCB_GO carries 3A/04; DONE=1.
- Entry 5 NACKs every attempt, MAX_RETRY=3 → 4 SCCB_GO pulses for entry 5, then ERR=1, ERR_INDEX=5, DONE=0, no access to entry 6.
- Entry 2 NACKs once, then ACKs → 2 pulses for entry 2; sequence continues; DONE=1; ERR=0.
- ADDR_W=2, table without FFFF → writes entries 0–3, then DONE=1; ROM_ADDR does not wrap to 0.
- RST asserted during WAIT_XFER → next cycle BUSY=0, DONE=0, ERR=0; no SCCB_GO afterwards. A later START reruns from entry 0. A START pulsed mid-run is ignored.
